// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 max-pooling over a raster-order pixel stream, using a half-width line buffer of pair maxima.
// Define MAXPOOL_SIGNED_EN to compare pixels as two's-complement signed values (default: unsigned).
module maxpool2x2_stream #(
    parameter int N     = 16,
    parameter int IMG_W = 24,
    parameter int IMG_H = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_rst,
    input  logic         din_vld,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         dout_vld,
    output logic         frame_done
);

    // Column index = {line-buffer address, odd/even bit}; IMG_W is even so AW+1 bits always cover it.
    localparam int AW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int CW = AW + 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB = (IMG_W >= 2) ? (IMG_W / 2) : 1;

    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
        $error("maxpool2x2_stream: IMG_W must be even and >= 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
        $error("maxpool2x2_stream: IMG_H must be even and >= 2");
    end

    function automatic logic [N-1:0] max2(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [N-1:0]  pair;
    logic [N-1:0]  linebuf [LB];

    logic [AW-1:0] lb_addr;
    logic          col_last;
    logic          row_last;
    logic          win_done;
    logic          lb_wr;
    logic [N-1:0]  hmax;
    logic [N-1:0]  result;

    assign lb_addr  = col[CW-1:1];
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign hmax     = max2(pair, din);
    assign result   = max2(linebuf[lb_addr], hmax);
    // A restart takes the concurrent pixel as (0,0), so it can neither close a window nor write the buffer.
    assign win_done = din_vld & ~frame_rst & col[0] & row[0];
    assign lb_wr    = din_vld & ~frame_rst & col[0] & ~row[0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            pair       <= '0;
            dout       <= '0;
            dout_vld   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout_vld   <= 1'b0;
            frame_done <= 1'b0;
            if (frame_rst) begin
                row  <= '0;
                col  <= din_vld ? CW'(1) : '0;
                pair <= din_vld ? din : '0;
            end else if (din_vld) begin
                if (!col[0]) begin
                    pair <= din;
                end
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) begin
                    row <= row_last ? '0 : row + RW'(1);
                end
                if (win_done) begin
                    dout       <= result;
                    dout_vld   <= 1'b1;
                    frame_done <= col_last & row_last;
                end
            end
        end
    end

    // NOTE: the line buffer has no reset; every entry is written on an even row before an odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_wr) begin
            linebuf[lb_addr] <= hmax;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench: a 4x4 and a 24x24 instance, each checked every cycle against a whole-window image model.
module tb_maxpool2x2_stream;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] din        [2];
    logic         din_vld    [2];
    logic         frame_rst  [2];
    logic [N-1:0] dout       [2];
    logic         dout_vld   [2];
    logic         frame_done [2];

    int errors = 0;
    int checks = 0;

    logic [N-1:0] obs [2][$];
    int           done_cnt [2];
    logic [N-1:0] exp_q [$];

    function automatic logic [N-1:0] mx(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int W = (g == 0) ? 4 : 24;
        localparam int H = (g == 0) ? 4 : 24;

        maxpool2x2_stream #(.N(N), .IMG_W(W), .IMG_H(H)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .frame_rst  (frame_rst[g]),
            .din_vld    (din_vld[g]),
            .din        (din[g]),
            .dout       (dout[g]),
            .dout_vld   (dout_vld[g]),
            .frame_done (frame_done[g])
        );

        // Model: keep the whole frame as an image and pool each 2x2 window when its last pixel arrives.
        logic [N-1:0] img [H][W];
        int           m_row;
        int           m_col;
        logic         e_vld  = 1'b0;
        logic         e_done = 1'b0;
        logic [N-1:0] e_dout = '0;

        always @(posedge clk) begin
            if (!rst_n) begin
                m_row  <= 0;
                m_col  <= 0;
                e_vld  <= 1'b0;
                e_done <= 1'b0;
                e_dout <= '0;
            end else begin
                int r;
                int c;
                r = frame_rst[g] ? 0 : m_row;
                c = frame_rst[g] ? 0 : m_col;
                e_vld  <= 1'b0;
                e_done <= 1'b0;
                if (din_vld[g]) begin
                    img[r][c] <= din[g];
                    if ((r % 2) == 1 && (c % 2) == 1) begin
                        e_dout <= mx(mx(img[r-1][c-1], img[r-1][c]), mx(img[r][c-1], din[g]));
                        e_vld  <= 1'b1;
                        e_done <= (r == H - 1) && (c == W - 1);
                    end
                    if (c == W - 1) begin
                        c = 0;
                        r = (r == H - 1) ? 0 : r + 1;
                    end else begin
                        c = c + 1;
                    end
                end
                m_row <= r;
                m_col <= c;
            end
        end

        always @(negedge clk) begin
            checks++;
            if (dout_vld[g] !== e_vld || frame_done[g] !== e_done || dout[g] !== e_dout) begin
                errors++;
                $display("FAIL lane%0d cycle_cmp @%0t: got vld=%b done=%b dout=%h, want vld=%b done=%b dout=%h",
                         g, $time, dout_vld[g], frame_done[g], dout[g], e_vld, e_done, e_dout);
            end
            if (dout_vld[g] === 1'b1) obs[g].push_back(dout[g]);
            if (frame_done[g] === 1'b1) done_cnt[g]++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_obs(input string name);
        check({name, "_count"}, obs[0].size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs[0].size(); i++) begin
            check($sformatf("%s_out%0d", name, i), obs[0][i], exp_q[i]);
        end
    endtask

    task automatic px(input int g, input logic [N-1:0] v, input bit fr = 1'b0);
        din[g]       = v;
        din_vld[g]   = 1'b1;
        frame_rst[g] = fr;
        @(negedge clk);
        din_vld[g]   = 1'b0;
        frame_rst[g] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs[0].delete();
        obs[1].delete();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int pr [4] = '{0, 0, 3, 3};
        int pc [4] = '{0, 3, 0, 3};
        for (int g = 0; g < 2; g++) begin
            din[g]       = '0;
            din_vld[g]   = 1'b0;
            frame_rst[g] = 1'b0;
        end
        clear_obs();

        rst_n = 1'b0;
        idle(3);
        check("rst_dout", dout[0], 0);
        check("rst_vld", dout_vld[0], 0);
        check("rst_done", frame_done[0], 0);
        rst_n = 1'b1;
        idle(2);

        // Ramp frame
        clear_obs();
        for (int i = 0; i < 16; i++) px(0, N'(i));
        idle(3);
        exp_q = '{16'd5, 16'd7, 16'd13, 16'd15};
        check_obs("ramp");
        check("ramp_done", done_cnt[0], 1);

        // Max in each corner, one window per placement
        for (int k = 0; k < 4; k++) begin
            clear_obs();
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    px(0, (r == pr[k] && c == pc[k]) ? 16'd100 : 16'd0);
            idle(3);
            exp_q = '{16'd0, 16'd0, 16'd0, 16'd0};
            exp_q[k] = 16'd100;
            check_obs($sformatf("corner%0d", k));
        end

        // Back-to-back frames
        clear_obs();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) px(0, N'(i + 20 * f));
        idle(3);
        exp_q = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd25, 16'd27, 16'd33, 16'd35};
        check_obs("b2b");
        check("b2b_done", done_cnt[0], 2);

        // Soft restart after 6 pixels; pixel 5 already closes window 0 of the aborted frame
        clear_obs();
        for (int i = 0; i < 6; i++) px(0, N'(i));
        px(0, 16'd0, 1'b1);
        for (int i = 1; i < 16; i++) px(0, N'(i));
        idle(3);
        exp_q = '{16'd5, 16'd5, 16'd7, 16'd13, 16'd15};
        check_obs("resync");
        check("resync_done", done_cnt[0], 1);

        // Hard reset mid-frame
        clear_obs();
        for (int i = 0; i < 6; i++) px(0, N'(i));
        rst_n = 1'b0;
        idle(1);
        check("midrst_dout", dout[0], 0);
        check("midrst_vld", dout_vld[0], 0);
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) px(0, N'(i));
        idle(3);
        exp_q = '{16'd5, 16'd5, 16'd7, 16'd13, 16'd15};
        check_obs("hardrst");
        check("hardrst_done", done_cnt[0], 1);

        // Sign-sensitive frame
        clear_obs();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                px(0, (r == 1 && c == 1) ? 16'h0001 : 16'hFFFF);
        idle(3);
`ifdef MAXPOOL_SIGNED_EN
        exp_q = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`else
        exp_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
`endif
        check_obs("sign");

        // Random 4x4 frames with random gaps
        clear_obs();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 16; i++) begin
                px(0, N'($urandom));
                idle($urandom_range(0, 2));
            end
        idle(3);
        check("rand4_count", obs[0].size(), 16);
        check("rand4_done", done_cnt[0], 4);

        // 24x24 ramp with random 0-3 cycle gaps
        clear_obs();
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++) begin
                px(1, N'(r * 24 + c));
                idle($urandom_range(0, 3));
            end
        idle(3);
        check("gap_count", obs[1].size(), 144);
        check("gap_done", done_cnt[1], 1);
        if (obs[1].size() == 144) begin
            check("gap_first", obs[1][0], 25);
            check("gap_last", obs[1][143], 575);
        end

        // 24x24 random data, gapped
        clear_obs();
        for (int i = 0; i < 24 * 24; i++) begin
            px(1, N'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        check("rand24_count", obs[1].size(), 144);
        check("rand24_done", done_cnt[1], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
